// File: rtl/riot_timer.sv
// riot_timer: RIOT-class interval timer with CNT_W-bit count and 4 dividers.
// Optional periodic reload under `RIOT_TIMER_RELOAD_EN.
// Ports:
//   phi2        clock, all state on rising edge
//   rst_n       synchronous active-low reset
//   sel, we_n   access select / 0=write 1=read
//   addr, DI    register address / write data
//   DO          combinational read data
//   irq_n       ~(flag & irq_en)
//   irq_en      interrupt enable (PB7 mux)
module riot_timer #(
  parameter int CNT_W     = 8,
  parameter int DIV1_LOG2 = 3,
  parameter int DIV2_LOG2 = 6,
  parameter int DIV3_LOG2 = 10
) (
  input  logic       phi2,
  input  logic       rst_n,
  input  logic       sel,
  input  logic       we_n,
  input  logic [3:0] addr,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  output logic       irq_n,
  output logic       irq_en
);

  localparam int PW = DIV3_LOG2;
  localparam logic [PW-1:0] LAST1 =
    PW'((2 ** DIV1_LOG2) - 1);
  localparam logic [PW-1:0] LAST2 =
    PW'((2 ** DIV2_LOG2) - 1);
  localparam logic [PW-1:0] LAST3 =
    PW'((2 ** DIV3_LOG2) - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] load_val;
  logic [1:0]       div_sel;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_last;
  logic             fast;
  logic             flag;
  logic [7:0]       hi_byte;

  logic wr, rd, is_cnt;
  logic wr_load, rd_cnt;
  logic tick, uflow;

  assign wr      = sel & ~we_n;
  assign rd      = sel & we_n;
  assign is_cnt  = ~addr[3] & (addr[1:0] == 2'b00);
  assign wr_load = wr & ~addr[3];
  assign rd_cnt  = rd & is_cnt;

  always_comb begin
    presc_last = LAST3;
    unique case (div_sel)
      2'b01:   presc_last = LAST1;
      2'b10:   presc_last = LAST2;
      default: presc_last = LAST3;
    endcase
  end

  // /1 and post-underflow run every cycle
  assign tick  = fast
               | (div_sel == 2'b00)
               | (presc == presc_last);
  assign uflow = tick & (count == '0);

  // High byte latch: coherent multi-byte reads
  if (CNT_W > 8) begin : g_hi
    logic [CNT_W-9:0] hold_hi;
    logic [CNT_W-9:0] rd_hi;

    always_ff @(posedge phi2) begin
      if (!rst_n) begin
        hold_hi <= '0;
        rd_hi   <= '0;
      end else begin
        if (wr && addr == 4'h8)
          hold_hi <= DI[CNT_W-9:0];
        if (rd_cnt)
          rd_hi <= count[CNT_W-1:8];
      end
    end

    assign load_val = {hold_hi, DI};
    assign hi_byte  = 8'(rd_hi);
  end else begin : g_no_hi
    assign load_val = DI;
    assign hi_byte  = 8'h00;
  end

`ifdef RIOT_TIMER_RELOAD_EN
  logic             reload;
  logic [CNT_W-1:0] reload_val;

  always_ff @(posedge phi2) begin
    if (!rst_n) begin
      reload     <= 1'b0;
      reload_val <= '0;
    end else begin
      if (wr && addr == 4'h9)
        reload <= DI[0];
      if (wr_load)
        reload_val <= load_val;
    end
  end
`endif

  always_ff @(posedge phi2) begin
    if (!rst_n) begin
      count   <= '1;
      div_sel <= 2'b11;
      presc   <= '0;
      fast    <= 1'b0;
      flag    <= 1'b0;
      irq_en  <= 1'b0;
    end else if (wr_load) begin
      // load wins over a same-edge underflow
      count   <= load_val;
      div_sel <= addr[1:0];
      presc   <= '0;
      fast    <= 1'b0;
      flag    <= 1'b0;
      irq_en  <= addr[2];
    end else begin
      presc <= tick ? '0 : presc + PW'(1);

      if (uflow) begin
`ifdef RIOT_TIMER_RELOAD_EN
        if (reload) begin
          count <= reload_val;
          fast  <= 1'b0;
        end else begin
          count <= '1;
          fast  <= 1'b1;
        end
`else
        count <= '1;
        fast  <= 1'b1;
`endif
      end else if (tick) begin
        count <= count - CNT_W'(1);
      end

      // underflow set beats read clear
      if (uflow)
        flag <= 1'b1;
      else if (rd_cnt)
        flag <= 1'b0;

      if (rd_cnt)
        irq_en <= addr[2];
    end
  end

  always_comb begin
    DO = 8'h00;
    unique case (1'b1)
      is_cnt:        DO = count[7:0];
      addr == 4'h1:  DO = {flag, 7'b0};
      addr == 4'h8:  DO = hi_byte;
`ifdef RIOT_TIMER_RELOAD_EN
      addr == 4'h9:  DO = {7'b0, reload};
`endif
      default:       DO = 8'h00;
    endcase
  end

  assign irq_n = ~(flag & irq_en);

endmodule

// File: tb/tb_riot_timer.sv
// tb_riot_timer: scoreboard bench for riot_timer.
// Drives 8-bit and 16-bit instances; monitor checks reads.
module tb_riot_timer;

  logic       phi2 = 1'b0;
  logic       rst_n = 1'b0;

  logic       sel8 = 1'b0, we8 = 1'b1;
  logic [3:0] a8 = '0;
  logic [7:0] di8 = '0, do8;
  logic       irqn8, en8;

  logic       sel16 = 1'b0, we16 = 1'b1;
  logic [3:0] a16 = '0;
  logic [7:0] di16 = '0, do16;
  logic       irqn16, en16;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      nm;
    logic [7:0] d;
    logic       in_n;
    logic       en;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  always #5 phi2 = ~phi2;

  riot_timer dut8 (
    .phi2   (phi2),
    .rst_n  (rst_n),
    .sel    (sel8),
    .we_n   (we8),
    .addr   (a8),
    .DI     (di8),
    .DO     (do8),
    .irq_n  (irqn8),
    .irq_en (en8)
  );

  riot_timer #(.CNT_W(16)) dut16 (
    .phi2   (phi2),
    .rst_n  (rst_n),
    .sel    (sel16),
    .we_n   (we16),
    .addr   (a16),
    .DI     (di16),
    .DO     (do16),
    .irq_n  (irqn16),
    .irq_en (en16)
  );

  task automatic chk(input exp_t e,
                     input logic [7:0] d,
                     input logic i,
                     input logic en);
    checks++;
    if ({d, i, en} !== {e.d, e.in_n, e.en}) begin
      failures++;
      $display("FAIL %s: got DO=%h irq_n=%b irq_en=%b want DO=%h irq_n=%b irq_en=%b",
               e.nm, d, i, en, e.d, e.in_n, e.en);
    end
  endtask

  // Monitor: a read presented to a DUT pops its expectation
  always @(negedge phi2) begin
    if (rst_n && sel8 && we8) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut8_unexpected_read: addr=%h", a8);
      end else begin
        chk(q8.pop_front(), do8, irqn8, en8);
      end
    end
    if (rst_n && sel16 && we16) begin
      if (q16.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut16_unexpected_read: addr=%h", a16);
      end else begin
        chk(q16.pop_front(), do16, irqn16, en16);
      end
    end
  end

  task automatic cyc();
    @(posedge phi2);
    #1;
  endtask

  task automatic idle(input int n);
    sel8  = 1'b0;
    sel16 = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic wr8(input logic [3:0] a, input logic [7:0] d);
    sel8 = 1'b1; we8 = 1'b0; a8 = a; di8 = d;
    sel16 = 1'b0;
    cyc();
  endtask

  task automatic rd8(input logic [3:0] a, input logic [7:0] d,
                     input logic i, input logic en,
                     input string nm);
    sel8 = 1'b1; we8 = 1'b1; a8 = a;
    sel16 = 1'b0;
    q8.push_back('{nm, d, i, en});
    cyc();
  endtask

  task automatic wr16(input logic [3:0] a, input logic [7:0] d);
    sel16 = 1'b1; we16 = 1'b0; a16 = a; di16 = d;
    sel8 = 1'b0;
    cyc();
  endtask

  task automatic rd16(input logic [3:0] a, input logic [7:0] d,
                      input logic i, input logic en,
                      input string nm);
    sel16 = 1'b1; we16 = 1'b1; a16 = a;
    sel8 = 1'b0;
    q16.push_back('{nm, d, i, en});
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;

    // reset state
    rd8(4'h1, 8'h00, 1'b1, 1'b0, "rst_flag");
    rd8(4'h0, 8'hFF, 1'b1, 1'b0, "rst_count");

    // /8 with IRQ on, load 4; index j = edges after load
    wr8(4'h5, 8'h04);
    rd8(4'h4, 8'h04, 1'b1, 1'b1, "div8_j0");
    idle(6);
    rd8(4'h4, 8'h04, 1'b1, 1'b1, "div8_j7");
    rd8(4'h4, 8'h03, 1'b1, 1'b1, "div8_j8");
    idle(22);
    rd8(4'h4, 8'h01, 1'b1, 1'b1, "div8_j31");
    rd8(4'h4, 8'h00, 1'b1, 1'b1, "div8_j32");
    idle(6);
    rd8(4'h4, 8'h00, 1'b1, 1'b1, "div8_j39");
    rd8(4'h4, 8'hFF, 1'b0, 1'b1, "uflow_j40");
    rd8(4'h1, 8'h00, 1'b1, 1'b1, "rdclr_flag");
    rd8(4'h0, 8'hFD, 1'b1, 1'b1, "fast_j42");
    rd8(4'h1, 8'h00, 1'b1, 1'b0, "rd0_irq_off");

    // write on an underflow edge wins
    wr8(4'h4, 8'h00);
    wr8(4'h4, 8'h55);
    rd8(4'h1, 8'h00, 1'b1, 1'b1, "wr_vs_uf_flag");
    rd8(4'h4, 8'h54, 1'b1, 1'b1, "wr_vs_uf_cnt");

    // read-clear on an underflow edge loses
    wr8(4'h4, 8'h01);
    idle(1);
    rd8(4'h4, 8'h00, 1'b1, 1'b1, "rd_uf_pre");
    rd8(4'h1, 8'h80, 1'b0, 1'b1, "rd_vs_uf_flag");
    rd8(4'h4, 8'hFE, 1'b0, 1'b1, "rd_vs_uf_cnt");
    rd8(4'h1, 8'h00, 1'b1, 1'b1, "rd_vs_uf_clr");

    // unused addresses / no high byte at CNT_W=8
    rd8(4'h8, 8'h00, 1'b1, 1'b1, "hi8_zero");
    rd8(4'hF, 8'h00, 1'b1, 1'b1, "unused_F");
`ifdef RIOT_TIMER_RELOAD_EN
    wr8(4'h9, 8'h01);
    wr8(4'h4, 8'h02);
    idle(1);
    rd8(4'h4, 8'h01, 1'b1, 1'b1, "rl_j1");
    rd8(4'h4, 8'h00, 1'b1, 1'b1, "rl_j2");
    rd8(4'h4, 8'h02, 1'b0, 1'b1, "rl_j3");
    rd8(4'h4, 8'h01, 1'b1, 1'b1, "rl_j4");
    rd8(4'h4, 8'h00, 1'b1, 1'b1, "rl_j5");
    rd8(4'h4, 8'h02, 1'b0, 1'b1, "rl_j6");
    rd8(4'h9, 8'h01, 1'b1, 1'b1, "rl_reg");
`else
    rd8(4'h9, 8'h00, 1'b1, 1'b1, "unused_9");
`endif

    // access coincident with reset is discarded
    rst_n = 1'b0;
    sel8 = 1'b1; we8 = 1'b0; a8 = 4'h5; di8 = 8'h10;
    cyc();
    rst_n = 1'b1;
    rd8(4'h1, 8'h00, 1'b1, 1'b0, "rst2_flag");
    rd8(4'h0, 8'hFF, 1'b1, 1'b0, "rst2_count");

    // 16-bit instance: coherent high byte
    wr16(4'h8, 8'h12);
    wr16(4'h0, 8'h34);
    idle(2);
    rd16(4'h0, 8'h32, 1'b1, 1'b0, "w16_lo");
    idle(60);
    rd16(4'h8, 8'h12, 1'b1, 1'b0, "w16_hi_held");
    rd16(4'h0, 8'hF4, 1'b1, 1'b0, "w16_lo_wrap");
    rd16(4'h8, 8'h11, 1'b1, 1'b0, "w16_hi_new");

    idle(2);
    checks++;
    if (q8.size() != 0 || q16.size() != 0) begin
      failures++;
      $display("FAIL drain: pending q8=%0d q16=%0d want 0",
               q8.size(), q16.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
